// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// One quotient bit per cycle, fixed latency of WIDTH+1 busy cycles.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for Start; OutC holds the last result
// ITER  | one restoring step per cycle, WIDTH steps in total
// FIX   | apply result sign, pulse Done, release Busy
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             RstN,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] InA,
    input  logic [WIDTH-1:0] InB,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] OutC
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state;
    logic             isRem;
    logic             negA;
    logic             negB;
    logic [WIDTH-1:0] aReg;
    logic [WIDTH-1:0] bReg;
    logic [WIDTH-1:0] remReg;
    logic [CW-1:0]    cnt;

    logic             startNegA;
    logic             startNegB;
    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;
    logic [1:0]       trialTop;
    logic [WIDTH-1:0] trialRem;
    logic             noBorrow;
    logic             quotNeg;
    logic [WIDTH-1:0] result;

    // Operand magnitudes captured on Start (signed ops only when Op[0]==0).
    always_comb begin
        startNegA = ~Op[0] & InA[WIDTH-1];
        startNegB = ~Op[0] & InB[WIDTH-1];
        absA      = startNegA ? -InA : InA;
        absB      = startNegB ? -InB : InB;
    end

    // Trial subtract {Rem,Amsb} - |B| as an add of the inverted divisor with carry-in 1.
    assign {trialTop, trialRem} = {1'b0, remReg, aReg[WIDTH-1]}
                                + {1'b0, ~{1'b0, bReg}}
                                + {{(WIDTH+1){1'b0}}, 1'b1};
    // When the carry is set the difference is below |B|, so bit WIDTH of T is always clear.
    assign noBorrow = (trialTop == 2'b10);

    // Final sign fix-up; a zero divisor keeps the all-ones quotient unnegated.
    always_comb begin
        quotNeg = (negA ^ negB) && (bReg != '0);
        if (isRem) begin
            result = negA ? -remReg : remReg;
        end else begin
            result = quotNeg ? -aReg : aReg;
        end
    end

    // Sequencer: Flush wins over everything, Done is a single-cycle pulse out of FIX.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state  <= IDLE;
            isRem  <= 1'b0;
            negA   <= 1'b0;
            negB   <= 1'b0;
            aReg   <= '0;
            bReg   <= '0;
            remReg <= '0;
            cnt    <= '0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
            OutC   <= '0;
        end else begin
            Done <= 1'b0;
            if (Flush) begin
                state <= IDLE;
                Busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (Start) begin
                            isRem  <= Op[1];
                            negA   <= startNegA;
                            negB   <= startNegB;
                            aReg   <= absA;
                            bReg   <= absB;
                            remReg <= '0;
                            cnt    <= CW'(WIDTH - 1);
                            Busy   <= 1'b1;
                            state  <= ITER;
                        end
                    end
                    ITER: begin
                        remReg <= noBorrow ? trialRem : {remReg[WIDTH-2:0], aReg[WIDTH-1]};
                        aReg   <= {aReg[WIDTH-2:0], noBorrow};
                        if (cnt == '0) begin
                            state <= FIX;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    FIX: begin
                        OutC  <= result;
                        Done  <= 1'b1;
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Randomized and directed bench for seq_divider (WIDTH=32) against an arithmetic model.
module tb_seq_divider;

    logic        Clk = 1'b0;
    logic        RstN = 1'b0;
    logic        Start = 1'b0;
    logic [1:0]  Op = 2'b00;
    logic [31:0] InA = '0;
    logic [31:0] InB = '0;
    logic        Flush = 1'b0;
    logic        Busy;
    logic        Done;
    logic [31:0] OutC;

    int checks = 0;
    int failures = 0;

    seq_divider #(.WIDTH(32)) dut (
        .Clk  (Clk),
        .RstN (RstN),
        .Start(Start),
        .Op   (Op),
        .InA  (InA),
        .InB  (InB),
        .Flush(Flush),
        .Busy (Busy),
        .Done (Done),
        .OutC (OutC)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    // RISC-V M-extension division semantics, from plain arithmetic.
    function automatic logic [31:0] refDiv(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
            sa = a;
            sb = b;
            return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    function automatic logic [31:0] pickVal();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            4: return $urandom_range(0, 300);
            5: return -$urandom_range(1, 300);
            default: return $urandom;
        endcase
    endfunction

    // Issues one op from the current (idle) cycle and waits for Done; expects fixed latency.
    task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input bit midStart);
        int n;
        Op = op;
        InA = a;
        InB = b;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        chk({tag, "_busy"}, 32'(Busy), 32'd1);
        n = 0;
        while (!Done && n < 60) begin
            if (midStart && n == 5) begin
                Start = 1'b1;
                Op = 2'($urandom);
                InA = $urandom;
                InB = $urandom;
            end else begin
                Start = 1'b0;
            end
            @(posedge Clk);
            #1;
            n++;
        end
        Start = 1'b0;
        chk({tag, "_latency"}, 32'(n), 32'd33);
        chk({tag, "_result"}, OutC, exp);
        chk({tag, "_busy_at_done"}, 32'(Busy), 32'd0);
    endtask

    initial begin
        logic [31:0] held;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        bit          sawDone;

        #12;
        chk("reset_busy", 32'(Busy), 32'd0);
        chk("reset_done", 32'(Done), 32'd0);
        chk("reset_outc", OutC, 32'd0);
        @(negedge Clk);
        RstN = 1'b1;
        @(posedge Clk);
        #1;

        runOp("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 1'b0);
        runOp("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 1'b0);
        runOp("div_m7_2", 2'b00, -32'd7, 32'd2, 32'hFFFF_FFFD, 1'b0);
        runOp("rem_m7_2", 2'b10, -32'd7, 32'd2, 32'hFFFF_FFFF, 1'b0);
        runOp("rem_7_m2", 2'b10, 32'd7, -32'd2, 32'd1, 1'b0);
        runOp("div_x_0", 2'b00, 32'h8000_0005, 32'd0, 32'hFFFF_FFFF, 1'b0);
        runOp("divu_x_0", 2'b01, 32'h8000_0005, 32'd0, 32'hFFFF_FFFF, 1'b0);
        runOp("rem_x_0", 2'b10, 32'h8000_0005, 32'd0, 32'h8000_0005, 1'b0);
        runOp("remu_x_0", 2'b11, 32'h8000_0005, 32'd0, 32'h8000_0005, 1'b0);
        runOp("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        runOp("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
        runOp("mid_start", 2'b01, 32'd1000, 32'd3, 32'd333, 1'b1);

        // Flush on iteration 10: no Done, Busy drops, OutC retained.
        held = OutC;
        Op = 2'b00;
        InA = 32'd12345;
        InB = 32'd7;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        repeat (9) begin
            @(posedge Clk);
            #1;
        end
        Flush = 1'b1;
        @(posedge Clk);
        #1;
        Flush = 1'b0;
        chk("flush_busy", 32'(Busy), 32'd0);
        chk("flush_done", 32'(Done), 32'd0);
        sawDone = 1'b0;
        repeat (40) begin
            @(posedge Clk);
            #1;
            if (Done || Busy) sawDone = 1'b1;
        end
        chk("flush_quiet", 32'(sawDone), 32'd0);
        chk("flush_outc", OutC, held);

        // Flush together with Start while idle drops the Start.
        Flush = 1'b1;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Flush = 1'b0;
        Start = 1'b0;
        chk("flush_start_busy", 32'(Busy), 32'd0);
        @(posedge Clk);
        #1;
        chk("flush_start_busy2", 32'(Busy), 32'd0);

        runOp("after_flush", 2'b00, 32'd12345, 32'd7, 32'd1763, 1'b0);

        // Randomized, issued back-to-back from the Done cycle.
        for (int i = 0; i < 150; i++) begin
            op = 2'($urandom);
            a = pickVal();
            b = pickVal();
            runOp("rand", op, a, b, refDiv(op, a, b), 1'b0);
        end

        // Asynchronous reset mid-op.
        Op = 2'b01;
        InA = 32'd999;
        InB = 32'd4;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        repeat (7) begin
            @(posedge Clk);
        end
        #1;
        RstN = 1'b0;
        #1;
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_outc", OutC, 32'd0);
        #2;
        RstN = 1'b1;
        @(posedge Clk);
        #1;
        chk("rst_stays_idle", 32'(Busy), 32'd0);
        runOp("after_rst", 2'b11, 32'd999, 32'd4, 32'd3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
